// File: rtl/hazard_ctrl_pkg.sv
// hazard_ctrl_pkg: shared definitions for the pipeline hazard control unit.
//   hz_state_e  - hazard FSM states (HZ_RUN, HZ_STALL, HZ_FLUSH)
//   sb_entry_t  - one scoreboard entry {valid, dst, regwrite, memread}
//   REG_ZERO    - architectural zero register, never a real dependency
//   sb_match()  - true when an entry produces the register being read
// SB_DST_W fixes the scoreboard's destination field width; hazard_ctrl's
// REG_AW must not exceed it.
package hazard_ctrl_pkg;

  localparam int unsigned SB_DST_W = 5;
  localparam logic [SB_DST_W-1:0] REG_ZERO = '0;

  typedef enum logic [1:0] {
    HZ_RUN,
    HZ_STALL,
    HZ_FLUSH
  } hz_state_e;

  typedef struct packed {
    logic                valid;
    logic [SB_DST_W-1:0] dst;
    logic                regwrite;
    logic                memread;
  } sb_entry_t;

  function automatic logic sb_match(input sb_entry_t e, input logic [SB_DST_W-1:0] r);
    return e.valid && e.regwrite && (e.dst != REG_ZERO) && (e.dst == r);
  endfunction

endpackage

// File: rtl/hazard_ctrl_sb_stage.sv
// hz_sb_stage: one registered scoreboard entry with asynchronous clear.
//   clk, rst_n - clock and asynchronous active-low reset (clears to invalid)
//   entry_d    - entry to capture at the next rising edge
//   entry_q    - registered entry
module hz_sb_stage
  import hazard_ctrl_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  input  sb_entry_t entry_d,
  output sb_entry_t entry_q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      entry_q <= '0;
    end else begin
      entry_q <= entry_d;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: hazard control unit beside the ID stage of the 5-stage pipe.
// Compares the ID instruction's sources against a registered shadow of the
// EX and MEM destinations, producing PC / IF-ID write enables, the ID/EX
// bubble select and the branch flush strobes, plus a saturating stall count.
//   clk, rst_n                  - clock, asynchronous active-low reset
//   id_valid, id_rs, id_rt      - ID instruction and its source registers
//   id_uses_rs, id_uses_rt      - which sources are actually read
//   id_dst, id_regwrite,
//   id_memread                  - ID destination / writes reg / is a load
//   br_taken                    - branch in EX resolved taken
//   pc_write, ifid_write        - PC and IF/ID enables (0 = hold)
//   ctrl_sel                    - 1 passes ID control, 0 inserts a bubble
//   ifid_flush, idex_flush      - clear strobes for a taken branch
//   stall_cycles                - saturating count of stall cycles
// Build option: HAZ_FORWARD_EN - EX/MEM forwarding exists, so only
// load-use dependencies on the EX entry stall.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int unsigned REG_AW = 5,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_uses_rs,
  input  logic              id_uses_rt,
  input  logic [REG_AW-1:0] id_dst,
  input  logic              id_regwrite,
  input  logic              id_memread,
  input  logic              br_taken,
  output logic              pc_write,
  output logic              ifid_write,
  output logic              ctrl_sel,
  output logic              ifid_flush,
  output logic              idex_flush,
  output logic [CNT_W-1:0]  stall_cycles
);

  sb_entry_t        ex_d, ex_q, mem_q;
  hz_state_e        state_d, state_q;
  logic             hazard, rs_hit, rt_hit;
  logic [CNT_W-1:0] stall_cycles_d, stall_cycles_q;

  hz_sb_stage u_ex (
    .clk     (clk),
    .rst_n   (rst_n),
    .entry_d (ex_d),
    .entry_q (ex_q)
  );

  hz_sb_stage u_mem (
    .clk     (clk),
    .rst_n   (rst_n),
    .entry_d (ex_q),
    .entry_q (mem_q)
  );

  // Register file writes before it reads, so the WB stage is never checked.
  always_comb begin
    rs_hit = 1'b0;
    rt_hit = 1'b0;
`ifdef HAZ_FORWARD_EN
    rs_hit = sb_match(ex_q, SB_DST_W'(id_rs)) && ex_q.memread;
    rt_hit = sb_match(ex_q, SB_DST_W'(id_rt)) && ex_q.memread;
`else
    rs_hit = sb_match(ex_q, SB_DST_W'(id_rs)) || sb_match(mem_q, SB_DST_W'(id_rs));
    rt_hit = sb_match(ex_q, SB_DST_W'(id_rt)) || sb_match(mem_q, SB_DST_W'(id_rt));
`endif
    hazard = id_valid && ((id_uses_rs && rs_hit) || (id_uses_rt && rt_hit));
  end

  // Only instructions actually issued into ID/EX enter the scoreboard.
  always_comb begin
    ex_d = '0;
    if (id_valid && ctrl_sel && !br_taken) begin
      ex_d.valid    = 1'b1;
      ex_d.dst      = SB_DST_W'(id_dst);
      ex_d.regwrite = id_regwrite;
      ex_d.memread  = id_memread;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= HZ_RUN;
      stall_cycles_q <= '0;
    end else begin
      state_q        <= state_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  // FLUSH lasts one cycle and then decides exactly like RUN.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      HZ_RUN, HZ_FLUSH: begin
        if (br_taken)    state_d = HZ_FLUSH;
        else if (hazard) state_d = HZ_STALL;
        else             state_d = HZ_RUN;
      end
      HZ_STALL: begin
        if (br_taken)     state_d = HZ_FLUSH;
        else if (!hazard) state_d = HZ_RUN;
        else              state_d = HZ_STALL;
      end
      default: state_d = HZ_RUN;
    endcase
  end

  // Every cycle heading into STALL is exactly a hazard cycle without a branch.
  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if ((state_d == HZ_STALL) && (stall_cycles_q != '1)) begin
      stall_cycles_d = stall_cycles_q + CNT_W'(1);
    end
  end

  // Control outputs are combinational; reset forces everything quiet.
  always_comb begin
    pc_write   = 1'b0;
    ifid_write = 1'b0;
    ctrl_sel   = 1'b0;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    if (rst_n) begin
      if (br_taken) begin
        pc_write   = 1'b1;
        ifid_write = 1'b1;
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
      end else if (!hazard) begin
        pc_write   = 1'b1;
        ifid_write = 1'b1;
        ctrl_sel   = 1'b1;
      end
    end
  end

  assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed self-checking bench for hazard_ctrl.
// A second instance with a 4-bit counter shares all inputs so counter
// saturation is reached in a few dozen cycles.
module tb_hazard_ctrl;

  logic        clk;
  logic        rst_n;
  logic        id_valid;
  logic [4:0]  id_rs, id_rt, id_dst;
  logic        id_uses_rs, id_uses_rt, id_regwrite, id_memread;
  logic        br_taken;
  logic        pc_write, ifid_write, ctrl_sel, ifid_flush, idex_flush;
  logic [15:0] stall_cycles;
  logic        s_pc_write, s_ifid_write, s_ctrl_sel, s_ifid_flush, s_idex_flush;
  logic [3:0]  s_stall_cycles;

  int n_checks;
  int n_fail;
  int exp_cnt;

  // Stall lengths for the two dependency kinds in this build.
`ifdef HAZ_FORWARD_EN
  localparam int LU_STALL  = 1;
  localparam int ALU_STALL = 0;
`else
  localparam int LU_STALL  = 2;
  localparam int ALU_STALL = 2;
`endif

  // Control vector order: {pc_write, ifid_write, ctrl_sel, ifid_flush, idex_flush}
  localparam logic [4:0] C_RUN   = 5'b11100;
  localparam logic [4:0] C_STALL = 5'b00000;
  localparam logic [4:0] C_FLUSH = 5'b11011;
  localparam logic [4:0] C_RST   = 5'b00000;

  hazard_ctrl #(.REG_AW(5), .CNT_W(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_dst(id_dst),
    .id_regwrite(id_regwrite), .id_memread(id_memread), .br_taken(br_taken),
    .pc_write(pc_write), .ifid_write(ifid_write), .ctrl_sel(ctrl_sel),
    .ifid_flush(ifid_flush), .idex_flush(idex_flush), .stall_cycles(stall_cycles)
  );

  hazard_ctrl #(.REG_AW(5), .CNT_W(4)) u_sat (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_dst(id_dst),
    .id_regwrite(id_regwrite), .id_memread(id_memread), .br_taken(br_taken),
    .pc_write(s_pc_write), .ifid_write(s_ifid_write), .ctrl_sel(s_ctrl_sel),
    .ifid_flush(s_ifid_flush), .idex_flush(s_idex_flush), .stall_cycles(s_stall_cycles)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 'h%0h expected 'h%0h", tag, obs, exp);
    end
  endtask

  task automatic check_ctl(input string tag, input logic [4:0] exp);
    check(tag, 32'({pc_write, ifid_write, ctrl_sel, ifid_flush, idex_flush}), 32'(exp));
    check({tag, ".sat"},
          32'({s_pc_write, s_ifid_write, s_ctrl_sel, s_ifid_flush, s_idex_flush}), 32'(exp));
  endtask

  task automatic id(input logic v, input int rs, input int rt, input logic urs,
                    input logic urt, input int dst, input logic rw, input logic mr);
    id_valid    = v;
    id_rs       = 5'(rs);
    id_rt       = 5'(rt);
    id_uses_rs  = urs;
    id_uses_rt  = urt;
    id_dst      = 5'(dst);
    id_regwrite = rw;
    id_memread  = mr;
  endtask

  task automatic nop();
    id(1'b0, 0, 0, 1'b0, 1'b0, 0, 1'b0, 1'b0);
  endtask

  // Two empty cycles retire anything left in EX and MEM.
  task automatic drain();
    repeat (2) begin
      @(negedge clk);
      nop();
      br_taken = 1'b0;
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    exp_cnt  = 0;
    rst_n    = 1'b0;
    br_taken = 1'b0;
    nop();

    // Reset: outputs quiet even with a valid independent instruction in ID.
    @(negedge clk);
    id(1'b1, 8, 9, 1'b1, 1'b1, 10, 1'b1, 1'b0);
    #1;
    check_ctl("reset_ctl", C_RST);
    check("reset_cnt", 32'(stall_cycles), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    nop();

    // lw $2 then add $3,$2,$4 (load-use through rs).
    @(negedge clk); id(1'b1, 1, 0, 1'b1, 1'b0, 2, 1'b1, 1'b1); #1;
    check_ctl("lw2_issue", C_RUN);
    for (int i = 0; i < LU_STALL; i++) begin
      @(negedge clk); id(1'b1, 2, 4, 1'b1, 1'b1, 3, 1'b1, 1'b0); #1;
      check_ctl("lu_stall", C_STALL);
    end
    @(negedge clk); id(1'b1, 2, 4, 1'b1, 1'b1, 3, 1'b1, 1'b0); #1;
    check_ctl("lu_release", C_RUN);
    exp_cnt += LU_STALL;
    @(negedge clk); nop(); #1;
    check("lu_cnt", 32'(stall_cycles), 32'(exp_cnt));

    // add $2,$1,$1 then sub $5,$2,$1 (ALU dependency).
    drain();
    @(negedge clk); id(1'b1, 1, 1, 1'b1, 1'b1, 2, 1'b1, 1'b0); #1;
    check_ctl("add2_issue", C_RUN);
    for (int i = 0; i < ALU_STALL; i++) begin
      @(negedge clk); id(1'b1, 2, 1, 1'b1, 1'b1, 5, 1'b1, 1'b0); #1;
      check_ctl("alu_stall", C_STALL);
    end
    @(negedge clk); id(1'b1, 2, 1, 1'b1, 1'b1, 5, 1'b1, 1'b0); #1;
    check_ctl("alu_release", C_RUN);
    exp_cnt += ALU_STALL;
    @(negedge clk); nop(); #1;
    check("alu_cnt", 32'(stall_cycles), 32'(exp_cnt));

    // lw $0 then add $1,$0,$0: register zero never creates a dependency.
    drain();
    @(negedge clk); id(1'b1, 1, 0, 1'b1, 1'b0, 0, 1'b1, 1'b1); #1;
    check_ctl("lw0_issue", C_RUN);
    @(negedge clk); id(1'b1, 0, 0, 1'b1, 1'b1, 1, 1'b1, 1'b0); #1;
    check_ctl("r0_no_stall", C_RUN);

    // Matching rs that is not actually read never stalls.
    drain();
    @(negedge clk); id(1'b1, 1, 0, 1'b1, 1'b0, 2, 1'b1, 1'b1); #1;
    @(negedge clk); id(1'b1, 2, 2, 1'b0, 1'b0, 7, 1'b1, 1'b0); #1;
    check_ctl("unused_src", C_RUN);

    // Load-use through rt: add $3,$4,$2.
    drain();
    @(negedge clk); id(1'b1, 1, 0, 1'b1, 1'b0, 2, 1'b1, 1'b1); #1;
    for (int i = 0; i < LU_STALL; i++) begin
      @(negedge clk); id(1'b1, 4, 2, 1'b1, 1'b1, 3, 1'b1, 1'b0); #1;
      check_ctl("rt_stall", C_STALL);
    end
    @(negedge clk); id(1'b1, 4, 2, 1'b1, 1'b1, 3, 1'b1, 1'b0); #1;
    check_ctl("rt_release", C_RUN);
    exp_cnt += LU_STALL;

    // Load-use coinciding with a taken branch: flush wins, no stall counted.
    // The flushed lw $3 must not enter EX, so add $4,$3,$3 then passes.
    drain();
    @(negedge clk); id(1'b1, 1, 0, 1'b1, 1'b0, 2, 1'b1, 1'b1); #1;
    @(negedge clk); id(1'b1, 2, 0, 1'b1, 1'b0, 3, 1'b1, 1'b1); br_taken = 1'b1; #1;
    check_ctl("br_flush", C_FLUSH);
    @(negedge clk); br_taken = 1'b0; id(1'b1, 3, 3, 1'b1, 1'b1, 4, 1'b1, 1'b0); #1;
    check_ctl("post_flush", C_RUN);
    check("br_cnt", 32'(stall_cycles), 32'(exp_cnt));

    // Reset in the middle of a stall: outputs drop at once, scoreboard empties.
    drain();
    @(negedge clk); id(1'b1, 1, 0, 1'b1, 1'b0, 2, 1'b1, 1'b1); #1;
    @(negedge clk); id(1'b1, 2, 4, 1'b1, 1'b1, 3, 1'b1, 1'b0); #1;
    check_ctl("pre_rst_stall", C_STALL);
    #2 rst_n = 1'b0;
    #1;
    check_ctl("mid_rst_ctl", C_RST);
    check("mid_rst_cnt", 32'(stall_cycles), 32'd0);
    @(negedge clk); rst_n = 1'b1; #1;
    check_ctl("post_rst_pass", C_RUN);
    exp_cnt = 0;

    // Saturation: 20 single-cycle load-use stalls.
    drain();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); id(1'b1, 1, 0, 1'b1, 1'b0, 2, 1'b1, 1'b1);
      @(negedge clk); id(1'b1, 2, 4, 1'b1, 1'b1, 3, 1'b1, 1'b0);
    end
    @(negedge clk); nop(); #1;
    check("sat_main_cnt", 32'(stall_cycles), 32'd20);
    check("sat_small_cnt", 32'(s_stall_cycles), 32'hF);
    @(negedge clk); id(1'b1, 1, 0, 1'b1, 1'b0, 2, 1'b1, 1'b1);
    @(negedge clk); id(1'b1, 2, 4, 1'b1, 1'b1, 3, 1'b1, 1'b0);
    @(negedge clk); nop(); #1;
    check("sat_small_hold", 32'(s_stall_cycles), 32'hF);
    check("sat_main_next", 32'(stall_cycles), 32'd21);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
